multicycle_control: RTL

Multicycle control sequencer for the LEGv8 datapath. It fetches one instruction at a time over a request/valid instruction-memory handshake and latches it into an instruction register. It then walks a per-class FSM, driving every datapath strobe, including the immediate-extender select (SignOp, movz, lsl), the ALU, the register file, data memory and PC update. It replaces the single-cycle combinational decoder and sits between the memories and the shared datapath.

---
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control sequencer: fetches into IR, then walks a
// per-class FSM driving the shared datapath strobes.
module multicycle_control (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        Zero,
  output logic [1:0]  SignOp,
  output logic        movz,
  output logic [1:0]  lsl,
  output logic        ALUSrc,
  output logic [3:0]  ALUOp,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ADD,
    C_SUB,
    C_AND,
    C_ORR,
    C_ADDI,
    C_SUBI,
    C_LDUR,
    C_STUR,
    C_B,
    C_CBZ,
    C_MOVZ,
    C_ILL
  } cls_t;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  state_t      state;
  state_t      state_nx;
  cls_t        cls;
  logic [10:0] op;
  logic        is_mem;
  logic        is_br;
  logic        held;

  assign op = IR[31:21];

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      (op == 11'b10001011000):      cls = C_ADD;
      (op == 11'b11001011000):      cls = C_SUB;
      (op == 11'b10001010000):      cls = C_AND;
      (op == 11'b10101010000):      cls = C_ORR;
      (op[10:1] == 10'b1001000100): cls = C_ADDI;
      (op[10:1] == 10'b1101000100): cls = C_SUBI;
      (op == 11'b11111000010):      cls = C_LDUR;
      (op == 11'b11111000000):      cls = C_STUR;
      (op[10:5] == 6'b000101):      cls = C_B;
      (op[10:3] == 8'b10110100):    cls = C_CBZ;
      (op[10:2] == 9'b110100101):   cls = C_MOVZ;
      default:                      cls = C_ILL;
    endcase
  end

  assign is_mem = (cls == C_LDUR) || (cls == C_STUR);
  assign is_br  = (cls == C_B) || (cls == C_CBZ);

  always_comb begin
    state_nx = state;
    case (state)
      S_RST:    state_nx = S_FETCH;
      S_FETCH:  if (imem_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = (cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (is_mem)     state_nx = S_MEM;
        else if (is_br) state_nx = S_FETCH;
        else            state_nx = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)
          state_nx = (cls == C_STUR) ? S_FETCH : S_WB;
      end
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_RST;
    endcase
  end

  // Extender/ALU selects stay stable for the whole instruction body
  assign held = (state == S_DECODE) || (state == S_EXEC) ||
                (state == S_MEM) || (state == S_WB);

  always_comb begin
    SignOp   = 2'b00;
    movz     = 1'b0;
    lsl      = 2'b00;
    ALUSrc   = 1'b0;
    ALUOp    = 4'b0000;
    Reg2Loc  = 1'b0;
    MemToReg = 1'b0;
    if (held) begin
      case (cls)
        C_ADD: ALUOp = ALU_ADD;
        C_SUB: ALUOp = ALU_SUB;
        C_AND: ALUOp = ALU_AND;
        C_ORR: ALUOp = ALU_ORR;
        C_ADDI: begin
          ALUOp  = ALU_ADD;
          ALUSrc = 1'b1;
        end
        C_SUBI: begin
          ALUOp  = ALU_SUB;
          ALUSrc = 1'b1;
        end
        C_LDUR: begin
          SignOp   = 2'b01;
          ALUOp    = ALU_ADD;
          ALUSrc   = 1'b1;
          MemToReg = 1'b1;
        end
        C_STUR: begin
          SignOp  = 2'b01;
          ALUOp   = ALU_ADD;
          ALUSrc  = 1'b1;
          Reg2Loc = 1'b1;
        end
        C_B: SignOp = 2'b10;
        C_CBZ: begin
          SignOp  = 2'b11;
          ALUOp   = ALU_PASS;
          Reg2Loc = 1'b1;
        end
        C_MOVZ: begin
          movz   = 1'b1;
          lsl    = IR[22:21];
          ALUOp  = ALU_PASS;
          ALUSrc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        if (is_br) begin
          PCWrite = 1'b1;
          PCSrc   = (cls == C_B) || Zero;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STUR);
        PCWrite  = (cls == C_STUR) && dmem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= S_RST;
      IR      <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_valid)
        IR <= imem_rdata;
      if (PCWrite)
        retired <= retired + 32'd1;
      if (state == S_DECODE && cls == C_ILL)
        illegal <= 1'b1;
    end
  end

endmodule
